// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the core data-memory port.
// Lower half of the address space is a word-addressed RAM that aliases on the
// unused upper bits. Upper half is a small MMIO window with a TX FIFO that
// streams to a peripheral over valid/ready, its status word, and a cycle counter.
module dmem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int FIFO_AW   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [31:0] TX_DATA_ADDR   = 32'hFFFF_FFF0;
    localparam logic [31:0] TX_STATUS_ADDR = 32'hFFFF_FFF1;
    localparam logic [31:0] CYCLES_ADDR    = 32'hFFFF_FFF2;
    localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};

    // Storage arrays (not reset; RAM contents survive reset)
    logic [31:0] ram_mem  [0:(2**ADDR_BITS)-1];
    logic [31:0] fifo_mem [0:(2**FIFO_AW)-1];

    // State flops
    logic [31:0]        q_dmem_q,  q_dmem_d;
    logic [FIFO_AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [FIFO_AW:0]   count_q,   count_d;
    logic               ovf_q,     ovf_d;
    logic [31:0]        cycles_q,  cycles_d;

    // Decode and handshake terms
    logic               is_ram_s;
    logic               is_tx_data_s;
    logic               is_tx_status_s;
    logic               is_cycles_s;
    logic               full_s;
    logic               empty_s;
    logic               pop_s;
    logic               push_req_s;
    logic               push_ok_s;
    logic [31:0]        status_s;
    logic [ADDR_BITS-1:0] ram_idx_s;

    assign ram_idx_s      = address_dmem[ADDR_BITS-1:0];
    assign is_ram_s       = ~address_dmem[31];
    assign is_tx_data_s   = (address_dmem == TX_DATA_ADDR);
    assign is_tx_status_s = (address_dmem == TX_STATUS_ADDR);
    assign is_cycles_s    = (address_dmem == CYCLES_ADDR);

    // Count never exceeds depth, so its MSB alone marks a full FIFO
    assign full_s     = count_q[FIFO_AW];
    assign empty_s    = (count_q == {(FIFO_AW+1){1'b0}});
    assign out_valid  = ~empty_s;
    assign out_data   = fifo_mem[rd_ptr_q];
    assign q_dmem     = q_dmem_q;

    assign pop_s      = out_valid & out_ready;
    assign push_req_s = wren & is_tx_data_s;
    // A pop on the same edge frees the slot a push into a full FIFO needs
    assign push_ok_s  = push_req_s & (~full_s | pop_s);

    // Status word layout: ovf at bit 10, full at 9, empty at 8, count in the low bits
    always_comb begin
        status_s               = 32'h0000_0000;
        status_s[10]           = ovf_q;
        status_s[9]            = full_s;
        status_s[8]            = empty_s;
        status_s[FIFO_AW:0]    = count_q;
    end

    // Read mux: selects pre-edge state for the address presented this cycle
    always_comb begin
        q_dmem_d = 32'h0000_0000;
        if (is_ram_s) begin
            q_dmem_d = ram_mem[ram_idx_s];
        end else if (is_tx_status_s) begin
            q_dmem_d = status_s;
        end else if (is_cycles_s) begin
            q_dmem_d = cycles_q;
        end else begin
            q_dmem_d = 32'h0000_0000;
        end
    end

    // Next-state for FIFO pointers, occupancy, sticky overflow and cycle counter
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        cycles_d = cycles_q + 32'h0000_0001;

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A dropped push sets overflow even if status is cleared on the same edge
        if (push_req_s && !push_ok_s) begin
            ovf_d = 1'b1;
        end else if (wren && is_tx_status_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (wren && is_cycles_s) begin
            cycles_d = data;
        end else begin
            cycles_d = cycles_q + 32'h0000_0001;
        end
    end

    // Control and read-data flops with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_dmem_q <= 32'h0000_0000;
            rd_ptr_q <= {FIFO_AW{1'b0}};
            wr_ptr_q <= {FIFO_AW{1'b0}};
            count_q  <= {(FIFO_AW+1){1'b0}};
            ovf_q    <= 1'b0;
            cycles_q <= 32'h0000_0000;
        end else begin
            q_dmem_q <= q_dmem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cycles_q <= cycles_d;
        end
    end

    // RAM and FIFO storage writes (read-before-write falls out of edge sampling)
    always_ff @(posedge clock) begin
        if (wren && is_ram_s) begin
            ram_mem[ram_idx_s] <= data;
        end
        if (push_ok_s) begin
            fifo_mem[wr_ptr_q] <= data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios followed by a randomized phase,
// all checked against a behavioural model (array RAM, queue FIFO, counter).
module tb_dmem_responder;

    localparam logic [31:0] TX_DATA   = 32'hFFFF_FFF0;
    localparam logic [31:0] TX_STATUS = 32'hFFFF_FFF1;
    localparam logic [31:0] CYCLES    = 32'hFFFF_FFF2;
    localparam int          DEPTH     = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ram [0:4095];
    logic [31:0] m_fifo [$];
    logic        m_ovf;
    logic [31:0] m_cyc;

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n = m_fifo.size();
        return {21'd0, m_ovf, (n == DEPTH) ? 1'b1 : 1'b0, (n == 0) ? 1'b1 : 1'b0,
                4'd0, n[3:0]};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!a[31])            return m_ram[a[11:0]];
        else if (a == TX_STATUS) return model_status();
        else if (a == CYCLES)  return m_cyc;
        else                   return 32'h0000_0000;
    endfunction

    // One bus cycle: drive after a falling edge, clock, then check on the next falling edge
    task automatic cycle(input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic rdy);
        logic [31:0] exp_q;
        logic        push_req, pop, acc;
        address_dmem = a;
        data         = d;
        wren         = we;
        out_ready    = rdy;
        exp_q    = model_read(a);
        push_req = we && (a == TX_DATA);
        pop      = (m_fifo.size() != 0) && rdy;
        acc      = push_req && ((m_fifo.size() < DEPTH) || pop);
        @(posedge clock);
        if (we && !a[31]) m_ram[a[11:0]] = d;
        if (pop) void'(m_fifo.pop_front());
        if (acc) m_fifo.push_back(d);
        if (push_req && !acc)          m_ovf = 1'b1;
        else if (we && a == TX_STATUS) m_ovf = 1'b0;
        m_cyc = (we && a == CYCLES) ? d : m_cyc + 32'd1;
        @(negedge clock);
        check("q_dmem", q_dmem, exp_q);
        check("out_valid", {31'd0, out_valid}, {31'd0, m_fifo.size() != 0});
        if (m_fifo.size() != 0) check("out_data", out_data, m_fifo[0]);
    endtask

    initial begin
        logic [31:0] a, d;
        int          op;
        reset = 1'b1; address_dmem = 32'd0; data = 32'd0; wren = 1'b0; out_ready = 1'b0;
        m_ovf = 1'b0; m_cyc = 32'd0;
        repeat (2) @(negedge clock);
        check("reset_q_dmem", q_dmem, 32'h0000_0000);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;

        // Fill the RAM words used by the bench
        for (int i = 0; i < 16; i++) cycle(32'(i), $urandom, 1'b1, 1'b0);

        // 1: write, read back directly and through an alias
        cycle(32'd5, 32'h0000_1234, 1'b1, 1'b0);
        cycle(32'd5, 32'd0, 1'b0, 1'b0);
        check("t1_rd5", q_dmem, 32'h0000_1234);
        cycle(32'd5 + 32'd4096, 32'd0, 1'b0, 1'b0);
        check("t1_rd_alias", q_dmem, 32'h0000_1234);

        // 2: three pushes with peripheral stalled, then drain
        cycle(TX_DATA, 32'hA, 1'b1, 1'b0);
        cycle(TX_DATA, 32'hB, 1'b1, 1'b0);
        cycle(TX_DATA, 32'hC, 1'b1, 1'b0);
        cycle(TX_STATUS, 32'd0, 1'b0, 1'b0);
        check("t2_status", q_dmem, 32'h0000_0003);
        check("t2_head", out_data, 32'hA);
        cycle(32'h8000_0000, 32'd0, 1'b0, 1'b1);
        check("t2_head_b", out_data, 32'hB);
        cycle(32'h8000_0000, 32'd0, 1'b0, 1'b1);
        check("t2_head_c", out_data, 32'hC);
        cycle(32'h8000_0000, 32'd0, 1'b0, 1'b1);
        check("t2_drained", {31'd0, out_valid}, 32'd0);
        cycle(TX_STATUS, 32'd0, 1'b0, 1'b0);
        check("t2_empty", q_dmem, 32'h0000_0100);

        // 3: overflow on the ninth push, then clear ovf
        for (int i = 0; i < 9; i++) cycle(TX_DATA, 32'h100 + 32'(i), 1'b1, 1'b0);
        cycle(TX_STATUS, 32'd0, 1'b0, 1'b0);
        check("t3_full_ovf", q_dmem, 32'h0000_0608);
        cycle(TX_STATUS, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cycle(TX_STATUS, 32'd0, 1'b0, 1'b0);
        check("t3_ovf_clr", q_dmem, 32'h0000_0208);
        check("t3_head", out_data, 32'h100);

        // 4: push into a full FIFO while popping
        cycle(TX_DATA, 32'h55, 1'b1, 1'b1);
        cycle(TX_STATUS, 32'd0, 1'b0, 1'b0);
        check("t4_status", q_dmem, 32'h0000_0208);
        check("t4_head", out_data, 32'h101);

        // 5: counter load and wrap
        cycle(CYCLES, 32'hFFFF_FFFE, 1'b1, 1'b0);
        cycle(CYCLES, 32'd0, 1'b0, 1'b0);
        check("t5_c0", q_dmem, 32'hFFFF_FFFE);
        cycle(CYCLES, 32'd0, 1'b0, 1'b0);
        check("t5_c1", q_dmem, 32'hFFFF_FFFF);
        cycle(CYCLES, 32'd0, 1'b0, 1'b0);
        check("t5_c2", q_dmem, 32'h0000_0000);

        // 6: drain, queue 4 entries, then reset mid-cycle
        for (int i = 0; i < DEPTH; i++) cycle(32'h8000_0000, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(TX_DATA, $urandom, 1'b1, 1'b0);
        check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_q", q_dmem, 32'h0000_0000);
        m_fifo.delete(); m_ovf = 1'b0; m_cyc = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        cycle(TX_STATUS, 32'd0, 1'b0, 1'b0);
        check("t6_status", q_dmem, 32'h0000_0100);
        cycle(32'd5, 32'd0, 1'b0, 1'b0);
        check("t6_ram5", q_dmem, 32'h0000_1234);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 6);
            d  = $urandom;
            case (op)
                0: cycle({1'b0, 19'($urandom), 8'd0, 4'($urandom)}, d, 1'b1, 1'($urandom));
                1: cycle({1'b0, 19'($urandom), 8'd0, 4'($urandom)}, d, 1'b0, 1'($urandom));
                2: cycle(TX_DATA, d, 1'b1, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
                3: cycle(TX_STATUS, d, 1'b0, 1'($urandom));
                4: cycle(TX_STATUS, d, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'($urandom));
                5: cycle(CYCLES, d, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 1'($urandom));
                default: begin
                    a = {1'b1, 31'($urandom)};
                    if (a == TX_DATA || a == TX_STATUS || a == CYCLES) a = 32'hFFFF_FFF3;
                    cycle(a, d, 1'($urandom), 1'($urandom));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
